// File: rtl/wb_initiator_bridge.sv
// Fetch/data port arbiter driving a single Wishbone classic initiator.
// Define WB_TIMEOUT_EN to enable the bus watchdog (err_o, TIMEOUT_CYCLES).
module wb_initiator_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_valid_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic [3:0]            d_wmask_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_done_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [3:0]            wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_D  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(32'hDEAD_BEEF);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_nx;
    logic   rr_if_first;
    logic   if_go;
    logic   d_go;
    logic   if_pick;
    logic   d_pick;
    logic   timeout;

    // A port whose completion pulse is high cannot re-request that cycle.
    assign if_go = if_req_i && !if_valid_o;
    assign d_go  = d_req_i && !d_done_o;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Count cycles spent on the bus; restarts for every transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !wb_ack_i &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Arbitration and next-state selection.
    always_comb begin
        state_nx = state;
        if_pick  = 1'b0;
        d_pick   = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    if_go && d_go: begin
                        if_pick = rr_if_first;
                        d_pick  = !rr_if_first;
                    end
                    if_go && !d_go: if_pick = 1'b1;
                    d_go && !if_go: d_pick = 1'b1;
                    default: ;
                endcase
                if (if_pick) begin
                    state_nx = BUS_IF;
                end else if (d_pick) begin
                    state_nx = BUS_D;
                end
            end
            BUS_IF, BUS_D: begin
                if (wb_ack_i || timeout) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and round-robin pointer (data wins after reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_if_first <= 1'b0;
        end else begin
            state <= state_nx;
            if (if_pick) begin
                rr_if_first <= 1'b0;
            end else if (d_pick) begin
                rr_if_first <= 1'b1;
            end
        end
    end

    // Bus cycle launch/termination and registered port results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_data_o  <= '0;
            wb_sel_o   <= 4'b0000;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
            if_valid_o <= 1'b0;
            d_done_o   <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            d_done_o   <= 1'b0;
            err_o      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_pick) begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b0;
                        wb_addr_o <= {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        wb_sel_o  <= 4'b1111;
                    end else if (d_pick) begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= d_we_i;
                        wb_addr_o <= {d_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        wb_data_o <= d_wdata_i;
                        wb_sel_o  <= d_we_i ? d_wmask_i : 4'b1111;
                    end
                end
                BUS_IF: begin
                    if (wb_ack_i || timeout) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                        if_valid_o <= 1'b1;
                        if_rdata_o <= wb_ack_i ? wb_data_i : FILL;
                        err_o      <= !wb_ack_i;
                    end
                end
                BUS_D: begin
                    if (wb_ack_i || timeout) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        d_done_o <= 1'b1;
                        err_o    <= !wb_ack_i;
                        if (!wb_we_o) begin
                            d_rdata_o <= wb_ack_i ? wb_data_i : FILL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Directed bench for wb_initiator_bridge: vector table plus
// hand sequences for arbitration, reset abort and watchdog.
module tb_wb_initiator_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [3:0]  d_wmask_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        err_o;

    wb_initiator_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o),
        .d_req_i(d_req_i),
        .d_we_i(d_we_i),
        .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i),
        .d_wmask_i(d_wmask_i),
        .d_rdata_o(d_rdata_o),
        .d_done_o(d_done_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o),
        .wb_sel_o(wb_sel_o),
        .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Responder: acks after ws wait states unless disabled.
    logic        resp_en = 1'b1;
    logic        spur = 1'b0;
    int          ws = 0;
    int          wcnt = 0;
    logic [31:0] resp_data = '0;

    always @(posedge clk) begin
        wcnt <= (wb_cyc_o && !wb_ack_i) ? wcnt + 1 : 0;
    end

    assign wb_ack_i  = spur || (resp_en && wb_cyc_o && wb_stb_o && wcnt >= ws);
    assign wb_data_i = resp_data;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          ws;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[6];
    vec_t        v;
    int          lat;
    logic        got;
    logic        first;
    logic        stable;
    logic        exp_we;
    logic        prev_cyc;
    int          gap_err;
    int          cyc_cnt;
    logic [31:0] grants[$];
    logic [31:0] exp_g[7] = '{32'h2000, 32'h1000, 32'h2000, 32'h1000,
                              32'h2000, 32'h1000, 32'h2000};

    // Raise the chosen requests together and service them to completion.
    task automatic run_reqs(input logic ri, input logic rd);
        @(negedge clk);
        prev_cyc  = wb_cyc_o;
        if_req_i  = ri;
        if_addr_i = 32'h1000;
        d_req_i   = rd;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h2000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wb_cyc_o && !prev_cyc) grants.push_back(wb_addr_o);
            if ((if_valid_o || d_done_o) && wb_cyc_o) gap_err++;
            if (if_valid_o) if_req_i = 1'b0;
            if (d_done_o) d_req_i = 1'b0;
            prev_cyc = wb_cyc_o;
            if (!if_req_i && !d_req_i && !wb_cyc_o && !if_valid_o && !d_done_o)
                break;
        end
        chk("rr_service_done", {30'd0, if_req_i, d_req_i}, 32'd0);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0102, 32'h0, 4'h0, 0,
                    32'h1234_5678, 32'h0000_0100, 4'hF, 2, 32'h1234_5678};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0011, 3,
                    32'hFFFF_0000, 32'h0000_0040, 4'b0011, 5, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2003, 32'h0, 4'b0101, 1,
                    32'hCAFE_F00D, 32'h0000_2000, 4'hF, 3, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1122_3344, 4'b1100, 0,
                    32'h7777_7777, 32'h0000_0044, 4'b1100, 2, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 2,
                    32'h0BAD_F00D, 32'hFFFF_FFFC, 4'hF, 4, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0, 4'b1000, 0,
                    32'h5A5A_A5A5, 32'h0000_0004, 4'hF, 2, 32'h5A5A_A5A5};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o,
                           if_valid_o, d_done_o, err_o, 1'b0}, 32'd0);
        chk("reset_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("reset_addr", wb_addr_o, 32'd0);
        chk("reset_wdata", wb_data_o, 32'd0);
        chk("reset_if_rdata", if_rdata_o, 32'd0);
        chk("reset_d_rdata", d_rdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v         = vecs[i];
            exp_we    = v.is_d && v.we;
            resp_data = v.rdata;
            ws        = v.ws;
            if (v.is_d) begin
                d_req_i   = 1'b1;
                d_we_i    = v.we;
                d_addr_i  = v.addr;
                d_wdata_i = v.wdata;
                d_wmask_i = v.mask;
            end else begin
                if_req_i  = 1'b1;
                if_addr_i = v.addr;
            end
            lat    = 0;
            got    = 1'b0;
            first  = 1'b1;
            stable = 1'b1;
            while (!got && lat < 50) begin
                @(negedge clk);
                lat++;
                if (wb_cyc_o) begin
                    if (first) begin
                        chk($sformatf("v%0d_addr", i), wb_addr_o, v.exp_addr);
                        chk($sformatf("v%0d_sel", i), {28'd0, wb_sel_o},
                            {28'd0, v.exp_sel});
                        chk($sformatf("v%0d_we", i), {31'd0, wb_we_o},
                            {31'd0, exp_we});
                        if (exp_we)
                            chk($sformatf("v%0d_wdata", i), wb_data_o, v.wdata);
                        first     = 1'b0;
                        if_req_i  = 1'b0;
                        d_req_i   = 1'b0;
                        if_addr_i = ~v.addr;
                        d_addr_i  = ~v.addr;
                        d_wdata_i = ~v.wdata;
                        d_wmask_i = ~v.mask;
                        d_we_i    = ~v.we;
                    end
                    if (wb_addr_o !== v.exp_addr || wb_sel_o !== v.exp_sel ||
                        wb_we_o !== exp_we || wb_stb_o !== 1'b1 ||
                        (exp_we && wb_data_o !== v.wdata))
                        stable = 1'b0;
                end
                if (if_valid_o || d_done_o) got = 1'b1;
            end
            if_req_i = 1'b0;
            d_req_i  = 1'b0;
            chk($sformatf("v%0d_stable", i), {31'd0, stable}, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
            chk($sformatf("v%0d_port", i), {30'd0, if_valid_o, d_done_o},
                {30'd0, !v.is_d, v.is_d});
            chk($sformatf("v%0d_rdata", i), v.is_d ? d_rdata_o : if_rdata_o,
                v.exp_rd);
            @(negedge clk);
            chk($sformatf("v%0d_single", i),
                {29'd0, if_valid_o, d_done_o, wb_cyc_o}, 32'd0);
        end

        // Spurious ack with no cycle open must be ignored.
        spur = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_ack", {29'd0, if_valid_o, d_done_o, wb_cyc_o}, 32'd0);
        end
        spur = 1'b0;
        @(negedge clk);
        chk("spur_after", {30'd0, if_valid_o, d_done_o}, 32'd0);

        // Reset in the middle of an unacknowledged read.
        resp_en  = 1'b0;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0300;
        repeat (3) @(negedge clk);
        chk("abort_cyc_open", {31'd0, wb_cyc_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {25'd0, wb_cyc_o, wb_stb_o, wb_we_o,
                           if_valid_o, d_done_o, err_o, 1'b0}, 32'd0);
        chk("abort_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("abort_addr", wb_addr_o, 32'd0);
        chk("abort_wdata", wb_data_o, 32'd0);
        chk("abort_rdata", if_rdata_o | d_rdata_o, 32'd0);
        d_req_i = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_pulse", {29'd0, if_valid_o, d_done_o, wb_cyc_o},
                32'd0);
        end

        // Round robin: simultaneous requests, data wins first after reset.
        ws      = 0;
        gap_err = 0;
        run_reqs(1'b1, 1'b1);
        run_reqs(1'b1, 1'b1);
        run_reqs(1'b0, 1'b1);
        run_reqs(1'b1, 1'b1);
        chk("rr_count", grants.size(), 7);
        for (int g = 0; g < 7; g++) begin
            if (g < grants.size())
                chk($sformatf("rr_grant%0d", g), grants[g], exp_g[g]);
        end
        chk("rr_idle_gap", gap_err, 0);

        // Responder that never acknowledges a data read.
        @(negedge clk);
        resp_en  = 1'b0;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_0500;
        cyc_cnt  = 0;
`ifdef WB_TIMEOUT_EN
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            d_req_i = 1'b0;
            if (d_done_o || err_o) got = 1'b1;
            else if (wb_cyc_o) cyc_cnt++;
        end
        chk("wd_cyc_cycles", cyc_cnt, 8);
        chk("wd_pulses", {29'd0, d_done_o, err_o, wb_cyc_o}, 32'b110);
        chk("wd_rdata", d_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wd_single", {30'd0, d_done_o, err_o}, 32'd0);
        resp_en = 1'b1;
`else
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            d_req_i = 1'b0;
            if (wb_cyc_o && !err_o && !d_done_o) cyc_cnt++;
        end
        chk("hang_cyc_cycles", cyc_cnt, 1000);
        resp_en = 1'b1;
        for (int c = 0; c < 5 && !got; c++) begin
            @(negedge clk);
            if (d_done_o) got = 1'b1;
        end
        chk("hang_release", {30'd0, got, err_o}, 32'b10);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_initiator_bridge.md
WB_INITIATOR_BRIDGE -- requirements
Module: wb_initiator_bridge

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, Wishbone address width; DATA_WIDTH, default 32, data width; TIMEOUT_CYCLES, default 255, watchdog limit (used only with WB_TIMEOUT_EN).
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 if_req_i  in  1  instruction fetch request (level, held until if_valid_o); if_addr_i  in  ADDR_WIDTH  fetch address.
REQ-004 if_rdata_o  out  DATA_WIDTH  fetched word; if_valid_o  out  1  one-cycle fetch-complete pulse.
REQ-005 d_req_i  in  1  data request (level); d_we_i  in  1  1=write; d_addr_i  in  ADDR_WIDTH; d_wdata_i  in  DATA_WIDTH; d_wmask_i  in  4  byte enables.
REQ-006 d_rdata_o  out  DATA_WIDTH  load data; d_done_o  out  1  one-cycle data-complete pulse.
REQ-007 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_addr_o  out  ADDR_WIDTH; wb_data_o  out  DATA_WIDTH; wb_sel_o  out  4; wb_data_i  in  DATA_WIDTH; wb_ack_i  in  1  -- Wishbone classic initiator.
REQ-008 err_o  out  1  one-cycle bus-timeout pulse.

Function
REQ-009 FSM states IDLE, BUS_IF, BUS_D; all outputs registered.
REQ-010 IDLE: if_req_i only -> BUS_IF; d_req_i only -> BUS_D; both -> grant the port not granted last (round-robin, data wins first conflict after reset); neither -> stay.
REQ-011 Request sampled in IDLE at edge N -> wb_cyc_o=wb_stb_o=1 from N+1; address, data, we, sel latched at edge N and held constant until termination.
REQ-012 wb_addr_o = request address with bits [1:0] forced 0; wb_sel_o = d_wmask_i for writes, 4'b1111 for reads; wb_we_o=1 only for data writes; fetches always reads.
REQ-013 wb_ack_i sampled 1 in BUS_* at edge M -> cyc/stb low from M+1, state IDLE, matching valid/done pulse high for exactly the cycle after M.
REQ-014 Read data captured from wb_data_i at edge M into if_rdata_o or d_rdata_o; held until next completion on that port; writes leave d_rdata_o unchanged.
REQ-015 wb_ack_i while wb_cyc_o=0 is ignored.
REQ-016 A port's request is ignored during the cycle its own valid/done pulse is high; minimum one idle cycle (cyc low) between transactions.
REQ-017 Request deasserted mid-transaction does not abort it; the transaction completes and pulses normally.
REQ-018 Zero-wait-state responder (ack in first stb cycle) gives 2-cycle request-to-pulse latency.

Reset
REQ-019 rst_n low asynchronously forces IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_addr_o=wb_data_o=0, wb_sel_o=0, if_rdata_o=d_rdata_o=0, if_valid_o=d_done_o=err_o=0, round-robin pointer to data-first, watchdog counter 0.
REQ-020 Reset mid-transaction drops cyc/stb immediately; no pulse is produced for the aborted transaction.

Configuration
REQ-021 Macro WB_TIMEOUT_EN defined: counter increments each cycle wb_cyc_o=1, clears on transaction start; on reaching TIMEOUT_CYCLES without ack, cyc/stb drop next cycle, state IDLE, port's valid/done pulses with rdata 32'hDEAD_BEEF (reads), err_o pulses same cycle.
REQ-022 Macro WB_TIMEOUT_EN undefined: no counter, bridge waits indefinitely for ack, err_o tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-023 Fetch 0x0000_0102, zero-wait responder returns 0x1234_5678 -> wb_addr_o=0x0000_0100, sel=4'hF, we=0, if_valid_o 2 cycles after request, if_rdata_o=0x1234_5678.
REQ-024 Data write addr 0x0000_0040, wdata 0xAABB_CCDD, mask 4'b0011, ack after 3 wait states -> we=1, sel=4'b0011, data stable all 4 stb cycles, single d_done_o pulse.
REQ-025 if_req_i and d_req_i rise same cycle twice in succession -> grants data, instruction, data, instruction; one idle cycle between each.
REQ-026 Spurious wb_ack_i in IDLE, then rst_n low mid-read with cyc high -> no pulse from spurious ack; cyc/stb low asynchronously, all outputs at reset values, no pulse after release.
REQ-027 WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never acks a data read -> cyc low after 8 cycles, d_done_o and err_o pulse together, d_rdata_o=0xDEAD_BEEF; without macro cyc stays high for 1000 cycles.
